// File: rtl/l1_meta_array.sv
// rtl/l1_meta_array.sv - L1 metadata array (SETS x WAYS of {tag, coh_state}) with self-init
//
// Optional feature macro: L1_META_HIT_CMP_EN (per-way hit compare plus resp_hit_any output).
//
// Ports:
//   clock, reset                         - single clock, asynchronous active-high reset
//   read_valid/read_ready                - read request handshake
//   read_idx, read_way_en, read_tag      - read set index, hit-eligible ways, compare tag
//   write_valid/write_ready              - write request handshake
//   write_idx, write_way_en              - write set index and target ways
//   write_coh_state, write_tag           - data stored into each enabled way
//   resp_valid                           - one-cycle pulse per accepted read
//   resp_tag, resp_coh                   - registered per-way contents of the read set
//   resp_hit                             - registered per-way hit vector (0 without the macro)
//   resp_hit_any                         - OR of resp_hit (only with the macro)
module l1_meta_array #(
    parameter int SETS  = 64,
    parameter int WAYS  = 8,
    parameter int TAG_W = 20,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read_valid,
    output logic                  read_ready,
    input  logic [IDX_W-1:0]      read_idx,
    input  logic [WAYS-1:0]       read_way_en,
    input  logic [TAG_W-1:0]      read_tag,
    input  logic                  write_valid,
    output logic                  write_ready,
    input  logic [IDX_W-1:0]      write_idx,
    input  logic [WAYS-1:0]       write_way_en,
    input  logic [1:0]            write_coh_state,
    input  logic [TAG_W-1:0]      write_tag,
    output logic                  resp_valid,
    output logic [WAYS*TAG_W-1:0] resp_tag,
    output logic [WAYS*2-1:0]     resp_coh,
`ifdef L1_META_HIT_CMP_EN
    output logic                  resp_hit_any,
`endif
    output logic [WAYS-1:0]       resp_hit
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;

    logic [TAG_W-1:0]  tag_mem [SETS][WAYS];
    logic [1:0]        coh_mem [SETS][WAYS];

    logic [WAYS*TAG_W-1:0] rd_tag;
    logic [WAYS*2-1:0]     rd_coh;
    logic                  read_fire;
    logic                  write_fire;

    logic                  resp_valid_q;
    logic [WAYS*TAG_W-1:0] resp_tag_q;
    logic [WAYS*2-1:0]     resp_coh_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Readiness depends only on state and write_valid so a requester can
    // never create a combinational loop through read_valid.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        read_ready  = 1'b0;
        write_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                write_ready = 1'b1;
                read_ready  = !write_valid;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign write_fire = write_valid && write_ready;
    assign read_fire  = read_valid && read_ready;

    // Storage carries no reset; the INIT sweep clears one set per cycle.
    always_ff @(posedge clock) begin
        for (int w = 0; w < WAYS; w++) begin
            if (state_q == ST_INIT) begin
                tag_mem[init_cnt_q][w] <= '0;
                coh_mem[init_cnt_q][w] <= 2'd0;
            end else if (write_fire && write_way_en[w]) begin
                tag_mem[write_idx][w] <= write_tag;
                coh_mem[write_idx][w] <= write_coh_state;
            end
        end
    end

    always_comb begin
        rd_tag = '0;
        rd_coh = '0;
        for (int w = 0; w < WAYS; w++) begin
            rd_tag[w*TAG_W +: TAG_W] = tag_mem[read_idx][w];
            rd_coh[2*w +: 2]         = coh_mem[read_idx][w];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_coh_q   <= '0;
        end else begin
            resp_valid_q <= read_fire;
            if (read_fire) begin
                resp_tag_q <= rd_tag;
                resp_coh_q <= rd_coh;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_tag   = resp_tag_q;
    assign resp_coh   = resp_coh_q;

`ifdef L1_META_HIT_CMP_EN
    logic [WAYS-1:0] hit_d;
    logic [WAYS-1:0] resp_hit_q;
    logic            resp_hit_any_q;

    always_comb begin
        hit_d = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_d[w] = read_way_en[w]
                     && (tag_mem[read_idx][w] == read_tag)
                     && (coh_mem[read_idx][w] != 2'd0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_hit_q     <= '0;
            resp_hit_any_q <= 1'b0;
        end else if (read_fire) begin
            resp_hit_q     <= hit_d;
            resp_hit_any_q <= |hit_d;
        end
    end

    assign resp_hit     = resp_hit_q;
    assign resp_hit_any = resp_hit_any_q;
`else
    // Compare inputs are intentionally ignored when no comparators are built.
    logic unused_cmp_inputs;
    assign unused_cmp_inputs = ^{read_way_en, read_tag};
    assign resp_hit          = '0;
`endif

endmodule
